mux_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 4:1 dataflow mux, letting four requesters share the single mux output. It drives the two mux select lines (`a`, `b`) and a one-hot grant, and holds each grant for a bounded burst of transfers. It also gates output validity against a downstream ready handshake. The block sits between the requesting sources and the mux, and owns all select sequencing.

---
 rtl/mux_rr_arbiter_pkg.sv | 21 ++
 rtl/mux_rr_arbiter_if.sv | 43 ++++
 rtl/mux_rr_arbiter_pick.sv | 25 ++
 rtl/mux_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and encodings for the 4:1 mux round-robin arbiter.
// Combinational definitions only; no latency, no flow control.
// Holds the FSM state enum and the mux select encodings (SEL_A..SEL_D).
package mux_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Select encoding {sel_b, sel_a} is simply the requester index.
    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/downstream bundle between the sources, the arbiter and the mux.
// No latency; pure wiring. Backpressure is carried by out_ready.
// The lock bus exists only when MUX_ARB_LOCK_EN is defined.
interface mux_rr_arbiter_if #(
    parameter int CW = 4
) ();
    logic [3:0]    req;
    logic          out_ready;
`ifdef MUX_ARB_LOCK_EN
    logic [3:0]    lock;
`endif
    logic [3:0]    gnt;
    logic          sel_a;
    logic          sel_b;
    logic          mux_valid;
    logic [CW-1:0] beat_cnt;

    modport master (
        input  req,
        input  out_ready,
`ifdef MUX_ARB_LOCK_EN
        input  lock,
`endif
        output gnt,
        output sel_a,
        output sel_b,
        output mux_valid,
        output beat_cnt
    );

    modport slave (
        output req,
        output out_ready,
`ifdef MUX_ARB_LOCK_EN
        output lock,
`endif
        input  gnt,
        input  sel_a,
        input  sel_b,
        input  mux_valid,
        input  beat_cnt
    );
endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// Round-robin winner search over four requests starting at ptr.
// Purely combinational, zero latency.
// No backpressure; any=0 when no request is pending.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] win_idx,
    output logic       any
);
    logic [1:0] idx;

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        win_idx = 2'd0;
        any     = 1'b0;
        idx     = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                win_idx = idx;
                any     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer driving the 4:1 mux selects and one-hot grant.
// Latency: req to gnt/sel 1 cycle; mux_valid combinational from registered gnt.
// Backpressure: out_ready low freezes the burst; MUX_ARB_LOCK_EN adds burst lock.
import mux_rr_arbiter_pkg::*;

module mux_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CW       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.master bus
);
    state_e        state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] beat_q, beat_d;

    logic [1:0]    pick_ptr;
    logic [1:0]    win_idx;
    logic          any;
    logic          mux_valid;
    logic          req_g;
    logic          beat;
    logic          cap_hit;
    logic          release_g;
    logic [1:0]    next_ptr;

    // While granted, sel_q is the granted index g.
    assign req_g     = bus.req[sel_q];
    assign mux_valid = |(gnt_q & bus.req);
    assign beat      = mux_valid & bus.out_ready;
    assign next_ptr  = sel_q + 2'd1;

`ifdef MUX_ARB_LOCK_EN
    assign cap_hit = beat && (beat_q >= CW'(MAX_HOLD - 1)) && !bus.lock[sel_q];
`else
    assign cap_hit = beat && (beat_q >= CW'(MAX_HOLD - 1));
`endif

    assign release_g = (state_q == ST_GRANT) && (!req_g || cap_hit);

    // Re-arbitration on release searches from g+1, leaving g lowest priority.
    assign pick_ptr = (state_q == ST_GRANT) ? next_ptr : ptr_q;

    rr_pick4 u_pick (
        .req     (bus.req),
        .ptr     (pick_ptr),
        .win_idx (win_idx),
        .any     (any)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    state_d = ST_GRANT;
                    gnt_d   = idx_to_onehot(win_idx);
                    sel_d   = win_idx;
                    ptr_d   = win_idx;
                    beat_d  = '0;
                end
            end
            ST_GRANT: begin
                if (release_g) begin
                    ptr_d  = next_ptr;
                    beat_d = '0;
                    if (any) begin
                        gnt_d = idx_to_onehot(win_idx);
                        sel_d = win_idx;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                    end
                end else if (beat) begin
`ifdef MUX_ARB_LOCK_EN
                    if (beat_q != {CW{1'b1}}) begin
                        beat_d = beat_q + CW'(1);
                    end
`else
                    beat_d = beat_q + CW'(1);
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= SEL_A;
            ptr_q   <= 2'd0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel_a     = sel_q[0];
    assign bus.sel_b     = sel_q[1];
    assign bus.mux_valid = mux_valid;
    assign bus.beat_cnt  = beat_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with hand-computed expectations.
module tb_mux_rr_arbiter;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    mux_rr_arbiter_if #(.CW(4)) bus_if ();

    mux_rr_arbiter #(.MAX_HOLD(4), .CW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.req = 4'b0000;
`ifdef MUX_ARB_LOCK_EN
        bus_if.lock = 4'b0000;
`endif
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] sel_of();
        return {30'd0, bus_if.sel_b, bus_if.sel_a};
    endfunction

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus_if.req       = 4'b0000;
        bus_if.out_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
        bus_if.lock      = 4'b0000;
`endif
        #12;
        check("rst_gnt", bus_if.gnt, 4'b0000);
        check("rst_sel", sel_of(), 2'b00);
        check("rst_beat", bus_if.beat_cnt, 0);
        check("rst_valid", bus_if.mux_valid, 0);
        tick();
        rst_n = 1'b1;

        // Single requester: grant, 4-beat cap, immediate re-grant, then drop.
        bus_if.req = 4'b0010;
        bus_if.out_ready = 1'b1;
        tick();
        check("s_gnt", bus_if.gnt, 4'b0010);
        check("s_sel", sel_of(), 2'b01);
        check("s_beat0", bus_if.beat_cnt, 0);
        check("s_valid", bus_if.mux_valid, 1);
        tick(); tick(); tick();
        check("s_beat3", bus_if.beat_cnt, 3);
        tick();
        check("s_regnt", bus_if.gnt, 4'b0010);
        check("s_regnt_beat", bus_if.beat_cnt, 0);
        bus_if.req = 4'b0000;
        tick();
        check("s_idle_gnt", bus_if.gnt, 4'b0000);
        check("s_idle_sel", sel_of(), 2'b01);
        check("s_idle_valid", bus_if.mux_valid, 0);

        // Fairness: all requesting, rotation 0,1,2,3 every 4 cycles.
        do_reset();
        bus_if.req = 4'b1111;
        for (int c = 0; c < 32; c++) begin
            tick();
            check($sformatf("f_gnt_%0d", c), bus_if.gnt, 32'(4'b0001 << ((c / 4) % 4)));
            check($sformatf("f_beat_%0d", c), bus_if.beat_cnt, 32'(c % 4));
        end

        // Stall on index 3.
        do_reset();
        bus_if.req = 4'b1000;
        tick();
        check("st_gnt", bus_if.gnt, 4'b1000);
        check("st_sel", sel_of(), 2'b11);
        tick();
        check("st_beat1", bus_if.beat_cnt, 1);
        bus_if.out_ready = 1'b0;
        repeat (10) tick();
        check("st_hold_gnt", bus_if.gnt, 4'b1000);
        check("st_hold_beat", bus_if.beat_cnt, 1);
        check("st_hold_valid", bus_if.mux_valid, 1);
        bus_if.out_ready = 1'b1;
        tick();
        check("st_beat2", bus_if.beat_cnt, 2);
        tick();
        check("st_beat3", bus_if.beat_cnt, 3);
        tick();
        check("st_done_beat", bus_if.beat_cnt, 0);
        check("st_done_gnt", bus_if.gnt, 4'b1000);

        // Early drop: index 1 leaves after 2 beats, index 2 takes over.
        do_reset();
        bus_if.req = 4'b0110;
        tick();
        check("ed_gnt1", bus_if.gnt, 4'b0010);
        tick(); tick();
        check("ed_beat2", bus_if.beat_cnt, 2);
        bus_if.req = 4'b0100;
        #1;
        check("ed_valid_drop", bus_if.mux_valid, 0);
        tick();
        check("ed_gnt2", bus_if.gnt, 4'b0100);
        check("ed_sel", sel_of(), 2'b10);
        check("ed_beat0", bus_if.beat_cnt, 0);

        // Asynchronous reset mid-burst on index 2.
        do_reset();
        bus_if.req = 4'b0100;
        tick(); tick(); tick();
        check("rm_beat2", bus_if.beat_cnt, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_gnt", bus_if.gnt, 4'b0000);
        check("rm_sel", sel_of(), 2'b00);
        check("rm_beat", bus_if.beat_cnt, 0);
        check("rm_valid", bus_if.mux_valid, 0);
        bus_if.req = 4'b1111;
        tick();
        rst_n = 1'b1;
        tick();
        check("rm_first", bus_if.gnt, 4'b0001);

`ifdef MUX_ARB_LOCK_EN
        // Lock extends index 0 past the cap until lock falls.
        do_reset();
        bus_if.req  = 4'b0011;
        bus_if.lock = 4'b0001;
        tick();
        check("lk_gnt0", bus_if.gnt, 4'b0001);
        repeat (9) tick();
        check("lk_hold", bus_if.gnt, 4'b0001);
        check("lk_beat9", bus_if.beat_cnt, 9);
        bus_if.lock = 4'b0000;
        tick();
        check("lk_rel", bus_if.gnt, 4'b0010);
        check("lk_beat0", bus_if.beat_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
